// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit in nickels, dispenses on reaching PRICE,
// then pays out the remainder (or a cancelled credit) as a paced train of single-nickel pulses.
module vend_ctrl #(
  parameter  int PRICE      = 3,
  parameter  int CHANGE_GAP = 1,
  localparam int CREDIT_W   = $clog2(PRICE + 5)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                candy,
  output logic                change,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int TOT_W = CREDIT_W + 1;
  localparam int GAP_W = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

  localparam logic [TOT_W-1:0]    PRICE_T    = TOT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(PRICE + 4);
  localparam logic [GAP_W-1:0]    GAP_LOAD   = GAP_W'(CHANGE_GAP - 1);

  typedef enum logic [1:0] {IDLE, VEND, CHG_ON, CHG_OFF} state_t;

  state_t              state_q, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [GAP_W-1:0]    gap_q, gap_nxt;
  logic [3:0]          coin_sum;
  logic [TOT_W-1:0]    tot;
  logic                coin_in;

  always_comb begin
    coin_sum   = {3'b000, nickel} + {2'b00, dime, 1'b0} + (quarter ? 4'd5 : 4'd0);
    tot        = {1'b0, credit} + TOT_W'(coin_sum);
    coin_in    = nickel | dime | quarter;
    state_nxt  = state_q;
    credit_nxt = credit;
    gap_nxt    = gap_q;
    case (state_q)
      IDLE: begin
        // A refund that would overflow the credit register is held at its ceiling.
        if (cancel && (tot != '0)) begin
          state_nxt  = CHG_ON;
          credit_nxt = (tot > {1'b0, MAX_CREDIT}) ? MAX_CREDIT : tot[CREDIT_W-1:0];
        end else if (tot >= PRICE_T) begin
          state_nxt  = VEND;
          credit_nxt = CREDIT_W'(tot - PRICE_T);
        end else begin
          credit_nxt = tot[CREDIT_W-1:0];
        end
      end
      VEND: begin
        state_nxt = (credit != '0) ? CHG_ON : IDLE;
      end
      CHG_ON: begin
        if (credit != '0) credit_nxt = credit - CREDIT_W'(1);
        state_nxt = CHG_OFF;
        gap_nxt   = GAP_LOAD;
      end
      CHG_OFF: begin
        if (gap_q == '0) state_nxt = (credit != '0) ? CHG_ON : IDLE;
        else             gap_nxt   = gap_q - GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      credit      <= '0;
      gap_q       <= '0;
      candy       <= 1'b0;
      change      <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      credit      <= credit_nxt;
      gap_q       <= gap_nxt;
      candy       <= (state_nxt == VEND);
      change      <= (state_nxt == CHG_ON);
      busy        <= (state_nxt != IDLE);
      coin_reject <= (state_q != IDLE) && coin_in;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: default instance plus a CHANGE_GAP=3 instance sharing inputs;
// per-cycle expectations are queued with their stimulus and compared as the cycles elapse.
module tb_vend_ctrl;

  localparam int CW = $clog2(3 + 5);

  logic clk, rst_n, nickel, dime, quarter, cancel;
  logic candy0, change0, reject0, busy0;
  logic candy1, change1, reject1, busy1;
  logic [CW-1:0] credit0, credit1;

  int checks = 0;
  int failures = 0;
  int cur = 0;
  int candy_cnt = 0;
  int change_cnt0 = 0;
  int change_cnt1 = 0;

  typedef enum int {S_CANDY, S_CHANGE, S_REJECT, S_BUSY, S_CREDIT} sig_e;
  typedef struct {int cyc; int inst; sig_e sig; int val; string tag;} exp_t;
  typedef struct {int cyc; logic n; logic d; logic q; logic c;} stim_t;

  exp_t  exp_q[$];
  stim_t stim_q[$];

  vend_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .cancel(cancel), .candy(candy0), .change(change0), .coin_reject(reject0),
    .credit(credit0), .busy(busy0)
  );

  vend_ctrl #(.PRICE(3), .CHANGE_GAP(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .cancel(cancel), .candy(candy1), .change(change1), .coin_reject(reject1),
    .credit(credit1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic d, input logic q, input logic c);
    nickel  = n;
    dime    = d;
    quarter = q;
    cancel  = c;
  endtask

  function automatic int readSig(input int inst, input sig_e s);
    case (s)
      S_CANDY:  return (inst == 0) ? int'(candy0)  : int'(candy1);
      S_CHANGE: return (inst == 0) ? int'(change0) : int'(change1);
      S_REJECT: return (inst == 0) ? int'(reject0) : int'(reject1);
      S_BUSY:   return (inst == 0) ? int'(busy0)   : int'(busy1);
      default:  return (inst == 0) ? int'(credit0) : int'(credit1);
    endcase
  endfunction

  task automatic pushExpect(input int cyc, input int inst, input sig_e sig, input int val,
                            input string tag);
    exp_t e;
    e.cyc = cyc; e.inst = inst; e.sig = sig; e.val = val; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic pushStim(input int cyc, input logic n, input logic d, input logic q,
                          input logic c);
    stim_t s;
    s.cyc = cyc; s.n = n; s.d = d; s.q = q; s.c = c;
    stim_q.push_back(s);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic startScenario();
    doReset();
    cur = 0; candy_cnt = 0; change_cnt0 = 0; change_cnt1 = 0;
    exp_q.delete();
    stim_q.delete();
  endtask

  // Each iteration samples cycle `cur` mid-cycle, then drives that cycle's inputs.
  task automatic runCycles(input int n);
    exp_t e;
    stim_t s;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cur) begin
        e = exp_q.pop_front();
        checkOutput(e.tag, readSig(e.inst, e.sig), e.val);
      end
      candy_cnt   += int'(candy0);
      change_cnt0 += int'(change0);
      change_cnt1 += int'(change1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (stim_q.size() > 0 && stim_q[0].cyc == cur) begin
        s = stim_q.pop_front();
        applyStimulus(s.n, s.d, s.q, s.c);
      end
      cur++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_unreached"}, -1, e.val);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_candy",  int'(candy0),  0);
    checkOutput("reset_change", int'(change0), 0);
    checkOutput("reset_reject", int'(reject0), 0);
    checkOutput("reset_busy",   int'(busy0),   0);
    checkOutput("reset_credit", int'(credit0), 0);

    // Exact price with three nickels.
    startScenario();
    pushStim(0, 1, 0, 0, 0); pushStim(1, 1, 0, 0, 0); pushStim(2, 1, 0, 0, 0);
    pushExpect(1, 0, S_CREDIT, 1, "exact_credit_c1");
    pushExpect(2, 0, S_CREDIT, 2, "exact_credit_c2");
    pushExpect(3, 0, S_CANDY,  1, "exact_candy_c3");
    pushExpect(3, 0, S_CREDIT, 0, "exact_credit_c3");
    pushExpect(3, 0, S_BUSY,   1, "exact_busy_c3");
    pushExpect(4, 0, S_BUSY,   0, "exact_busy_c4");
    pushExpect(4, 0, S_CANDY,  0, "exact_candy_c4");
    runCycles(7);
    checkOutput("exact_change_total", change_cnt0, 0);
    checkOutput("exact_candy_total",  candy_cnt,   1);

    // Overpay with a quarter; instance 1 paces change with a 3-cycle gap.
    startScenario();
    pushStim(0, 0, 0, 1, 0);
    pushExpect(1, 0, S_CANDY,  1, "over_candy_c1");
    pushExpect(1, 0, S_CREDIT, 2, "over_credit_c1");
    pushExpect(2, 0, S_CHANGE, 1, "over_change_c2");
    pushExpect(2, 0, S_CREDIT, 2, "over_credit_c2");
    pushExpect(2, 1, S_CHANGE, 1, "gap3_change_c2");
    pushExpect(3, 0, S_CHANGE, 0, "over_change_c3");
    pushExpect(3, 0, S_CREDIT, 1, "over_credit_c3");
    pushExpect(3, 1, S_CHANGE, 0, "gap3_change_c3");
    pushExpect(4, 0, S_CHANGE, 1, "over_change_c4");
    pushExpect(4, 1, S_CHANGE, 0, "gap3_change_c4");
    pushExpect(5, 0, S_CHANGE, 0, "over_change_c5");
    pushExpect(5, 0, S_CREDIT, 0, "over_credit_c5");
    pushExpect(5, 0, S_BUSY,   1, "over_busy_c5");
    pushExpect(5, 1, S_CHANGE, 0, "gap3_change_c5");
    pushExpect(6, 0, S_BUSY,   0, "over_busy_c6");
    pushExpect(6, 1, S_CHANGE, 1, "gap3_change_c6");
    pushExpect(7, 1, S_CREDIT, 0, "gap3_credit_c7");
    pushExpect(9, 1, S_BUSY,   1, "gap3_busy_c9");
    pushExpect(10, 1, S_BUSY,  0, "gap3_busy_c10");
    runCycles(12);
    checkOutput("over_change_total", change_cnt0, 2);
    checkOutput("gap3_change_total", change_cnt1, 2);
    checkOutput("over_candy_total",  candy_cnt,   1);

    // Nickel and dime together reach the price exactly.
    startScenario();
    pushStim(0, 1, 1, 0, 0);
    pushExpect(1, 0, S_CANDY,  1, "simul_candy_c1");
    pushExpect(1, 0, S_CREDIT, 0, "simul_credit_c1");
    pushExpect(2, 0, S_BUSY,   0, "simul_busy_c2");
    pushExpect(2, 0, S_CHANGE, 0, "simul_change_c2");
    runCycles(4);
    checkOutput("simul_change_total", change_cnt0, 0);

    // Cancel beats vending in the same cycle and refunds all four nickels.
    startScenario();
    pushStim(0, 0, 1, 0, 0); pushStim(2, 0, 1, 0, 1);
    pushExpect(1, 0, S_CREDIT, 2, "refund_credit_c1");
    pushExpect(1, 0, S_BUSY,   0, "refund_busy_c1");
    pushExpect(2, 0, S_CREDIT, 2, "refund_credit_c2");
    pushExpect(3, 0, S_CANDY,  0, "refund_candy_c3");
    pushExpect(3, 0, S_CHANGE, 1, "refund_change_c3");
    pushExpect(3, 0, S_BUSY,   1, "refund_busy_c3");
    pushExpect(3, 0, S_CREDIT, 4, "refund_credit_c3");
    pushExpect(4, 0, S_CHANGE, 0, "refund_change_c4");
    pushExpect(4, 0, S_CREDIT, 3, "refund_credit_c4");
    pushExpect(5, 0, S_CHANGE, 1, "refund_change_c5");
    pushExpect(7, 0, S_CHANGE, 1, "refund_change_c7");
    pushExpect(9, 0, S_CHANGE, 1, "refund_change_c9");
    pushExpect(9, 0, S_CREDIT, 1, "refund_credit_c9");
    pushExpect(10, 0, S_BUSY,   1, "refund_busy_c10");
    pushExpect(10, 0, S_CHANGE, 0, "refund_change_c10");
    pushExpect(10, 0, S_CREDIT, 0, "refund_credit_c10");
    pushExpect(11, 0, S_BUSY,   0, "refund_busy_c11");
    runCycles(13);
    checkOutput("refund_change_total", change_cnt0, 4);
    checkOutput("refund_candy_total",  candy_cnt,   0);

    // A coin during change payout is rejected and not credited.
    startScenario();
    pushStim(0, 0, 0, 1, 0); pushStim(2, 1, 0, 0, 0);
    pushExpect(2, 0, S_REJECT, 0, "reject_c2");
    pushExpect(3, 0, S_REJECT, 1, "reject_c3");
    pushExpect(3, 0, S_CREDIT, 1, "reject_credit_c3");
    pushExpect(4, 0, S_REJECT, 0, "reject_c4");
    pushExpect(4, 0, S_CREDIT, 1, "reject_credit_c4");
    pushExpect(5, 0, S_CREDIT, 0, "reject_credit_c5");
    pushExpect(6, 0, S_BUSY,   0, "reject_busy_c6");
    runCycles(8);
    checkOutput("reject_change_total", change_cnt0, 2);

    // Cancel with no credit does nothing.
    startScenario();
    pushStim(0, 0, 0, 0, 1);
    pushExpect(1, 0, S_BUSY,   0, "cancel0_busy_c1");
    pushExpect(1, 0, S_CHANGE, 0, "cancel0_change_c1");
    pushExpect(1, 0, S_CREDIT, 0, "cancel0_credit_c1");
    runCycles(3);

    // Asynchronous reset in the middle of a change gap forfeits the remainder.
    startScenario();
    pushStim(0, 0, 0, 1, 0);
    pushExpect(1, 0, S_CANDY, 1, "rst_pre_candy_c1");
    runCycles(3);
    @(posedge clk);
    #1;
    checkOutput("rst_pre_credit", int'(credit0), 1);
    checkOutput("rst_pre_busy",   int'(busy0),   1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_candy",  int'(candy0),  0);
    checkOutput("rst_async_change", int'(change0), 0);
    checkOutput("rst_async_reject", int'(reject0), 0);
    checkOutput("rst_async_busy",   int'(busy0),   0);
    checkOutput("rst_async_credit", int'(credit0), 0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_busy", int'(busy0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = 0; change_cnt0 = 0;
    pushExpect(1, 0, S_CREDIT, 0, "rst_post_credit_c1");
    pushExpect(3, 0, S_BUSY,   0, "rst_post_busy_c3");
    pushExpect(5, 0, S_CREDIT, 0, "rst_post_credit_c5");
    runCycles(6);
    checkOutput("rst_post_change_total", change_cnt0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
